mem_arbiter: RTL and testbench

Shares one single-port, fixed-latency unified memory between the core's instruction-fetch port and its load/store port, so instruction and data memories can move out of the core. Sequences each access as a request, memory access, latency wait and response; alternates grants on contention. Generates byte strobes and store lane replication from `funct3`, and performs load sign/zero extension.

---
 rtl/mem_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port, fixed-latency memory between the instruction-fetch
// port (i_*) and the load/store port (d_*). Each access is granted in IDLE, then runs
// ACCESS (mem_en), WAIT (MEM_LAT cycles, reads only) and RESP (one-cycle valid pulse).
// Ties alternate against last_owner. Stores get lane-replicated data and byte strobes;
// loads get sign/zero extension. Misaligned or illegal data requests answer with d_err
// without touching memory.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   i_req/i_addr            fetch request and word address
//   i_rdata/i_valid         fetched word and one-cycle completion pulse
//   d_req/d_we/d_funct3     data request, store flag, RV32I width code
//   d_addr/d_wdata          byte address, right-aligned store data
//   d_rdata/d_valid/d_err   extended load data, completion pulse, error flag
//   mem_en/mem_we/mem_wstrb memory strobe, write enable, byte strobes
//   mem_addr/mem_wdata      word address, lane-replicated store data
//   mem_rdata               read data, valid MEM_LAT cycles after mem_en
//   busy                    high whenever the arbiter is not idle
module mem_arbiter #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_valid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        d_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_t;

    localparam logic OwnFetch = 1'b0;
    localparam logic OwnData  = 1'b1;

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic        owner_q;
    logic        last_owner_q;
    logic        we_q;
    logic [1:0]  lane_q;
    logic [2:0]  funct3_q;

    logic        grant_data;
    logic        data_err;
    logic [31:2] sel_word;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // Fetch address bits [1:0] are don't-care.
    logic unused_bits;
    assign unused_bits = ^i_addr[1:0];

    // Data wins when alone, or on a tie when fetch was served last.
    assign grant_data = d_req && (!i_req || last_owner_q == OwnFetch);
    assign sel_word   = grant_data ? d_addr[31:2] : i_addr[31:2];

    always_comb begin
        data_err = 1'b0;
        case (d_funct3)
            3'b011, 3'b110, 3'b111: data_err = 1'b1;
            3'b001, 3'b101:         data_err = d_addr[0];
            3'b010:                 data_err = (d_addr[1:0] != 2'b00);
            default:                data_err = 1'b0;
        endcase
    end

    always_comb begin
        st_wdata = d_wdata;
        st_wstrb = 4'b1111;
        case (d_funct3[1:0])
            2'b00: begin
                st_wdata = {4{d_wdata[7:0]}};
                st_wstrb = 4'b0001 << d_addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{d_wdata[15:0]}};
                st_wstrb = d_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (lane_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= 3'd0;
            owner_q      <= OwnFetch;
            last_owner_q <= OwnFetch;
            we_q         <= 1'b0;
            lane_q       <= 2'd0;
            funct3_q     <= 3'd0;
            i_rdata      <= 32'h0;
            i_valid      <= 1'b0;
            d_rdata      <= 32'h0;
            d_valid      <= 1'b0;
            d_err        <= 1'b0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_wstrb    <= 4'h0;
            mem_addr     <= 32'h0;
            mem_wdata    <= 32'h0;
            busy         <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (i_req || d_req) begin
                        busy         <= 1'b1;
                        owner_q      <= grant_data;
                        last_owner_q <= grant_data;
                        we_q         <= grant_data & d_we;
                        lane_q       <= d_addr[1:0];
                        funct3_q     <= d_funct3;
                        if (grant_data && data_err) begin
                            state_q <= StResp;
                            d_valid <= 1'b1;
                            d_err   <= 1'b1;
                            d_rdata <= 32'h0;
                        end else begin
                            state_q   <= StAccess;
                            mem_en    <= 1'b1;
                            mem_addr  <= {sel_word, 2'b00};
                            mem_we    <= grant_data & d_we;
                            mem_wstrb <= (grant_data && d_we) ? st_wstrb : 4'h0;
                            mem_wdata <= (grant_data && d_we) ? st_wdata : 32'h0;
                        end
                    end
                end
                StAccess: begin
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_wstrb <= 4'h0;
                    mem_addr  <= 32'h0;
                    mem_wdata <= 32'h0;
                    if (we_q) begin
                        state_q <= StResp;
                        d_valid <= 1'b1;
                        d_rdata <= 32'h0;
                    end else begin
                        state_q <= StWait;
                        cnt_q   <= 3'(MEM_LAT - 1);
                    end
                end
                StWait: begin
                    if (cnt_q == 3'd0) begin
                        // Last wait cycle: mem_rdata is valid now.
                        state_q <= StResp;
                        if (owner_q == OwnData) begin
                            d_valid <= 1'b1;
                            d_rdata <= ld_ext;
                        end else begin
                            i_valid <= 1'b1;
                            i_rdata <= mem_rdata;
                        end
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: begin
                    // RESP: requests are not sampled here.
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    i_valid <= 1'b0;
                    i_rdata <= 32'h0;
                    d_valid <= 1'b0;
                    d_rdata <= 32'h0;
                    d_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] mem_rdata;

    // Outputs of the MEM_LAT=2 instance
    logic [31:0] l2_i_rdata, l2_d_rdata, l2_mem_addr, l2_mem_wdata;
    logic        l2_i_valid, l2_d_valid, l2_d_err, l2_mem_en, l2_mem_we, l2_busy;
    logic [3:0]  l2_mem_wstrb;
    // Outputs of the MEM_LAT=1 instance
    logic [31:0] l1_i_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata;
    logic        l1_i_valid, l1_d_valid, l1_d_err, l1_mem_en, l1_mem_we, l1_busy;
    logic [3:0]  l1_mem_wstrb;

    logic [137:0] l1_outs, l2_outs;
    assign l1_outs = {l1_i_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata, l1_mem_wstrb,
                      l1_i_valid, l1_d_valid, l1_d_err, l1_mem_en, l1_mem_we, l1_busy};
    assign l2_outs = {l2_i_rdata, l2_d_rdata, l2_mem_addr, l2_mem_wdata, l2_mem_wstrb,
                      l2_i_valid, l2_d_valid, l2_d_err, l2_mem_en, l2_mem_we, l2_busy};

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    mem_arbiter #(.MEM_LAT(2)) dut_l2 (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(l2_i_rdata), .i_valid(l2_i_valid),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(l2_d_rdata), .d_valid(l2_d_valid), .d_err(l2_d_err),
        .mem_en(l2_mem_en), .mem_we(l2_mem_we), .mem_wstrb(l2_mem_wstrb),
        .mem_addr(l2_mem_addr), .mem_wdata(l2_mem_wdata), .mem_rdata(mem_rdata),
        .busy(l2_busy)
    );

    mem_arbiter #(.MEM_LAT(1)) dut_l1 (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(l1_i_rdata), .i_valid(l1_i_valid),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(l1_d_rdata), .d_valid(l1_d_valid), .d_err(l1_d_err),
        .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_wstrb(l1_mem_wstrb),
        .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata), .mem_rdata(mem_rdata),
        .busy(l1_busy)
    );

    // Advance one cycle; inputs set after this are seen at the next edge.
    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_funct3 = 3'b000; d_addr = 32'h0; d_wdata = 32'h0;
        mem_rdata = 32'h0;
        step;
        step;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        total++; if (l1_outs !== 138'h0) begin bad++;
            $display("FAIL reset_l1_outs got=%h exp=0", l1_outs); end
        total++; if (l2_outs !== 138'h0) begin bad++;
            $display("FAIL reset_l2_outs got=%h exp=0", l2_outs); end
    endtask

    task automatic test_fetch;
        do_reset;
        mem_rdata = 32'h00A00093;
        i_addr = 32'h104; i_req = 1'b1;                       // cycle t
        step;                                                 // t+1
        total++; if ({l2_mem_en, l2_mem_we, l2_busy} !== 3'b101) begin bad++;
            $display("FAIL fetch_access got=%b exp=101", {l2_mem_en, l2_mem_we, l2_busy}); end
        total++; if (l2_mem_addr !== 32'h104) begin bad++;
            $display("FAIL fetch_mem_addr got=%h exp=00000104", l2_mem_addr); end
        step;                                                 // t+2
        total++; if ({l2_mem_en, l2_i_valid} !== 2'b00) begin bad++;
            $display("FAIL fetch_t2 got=%b exp=00", {l2_mem_en, l2_i_valid}); end
        step;                                                 // t+3
        total++; if (l2_i_valid !== 1'b0) begin bad++;
            $display("FAIL fetch_early_valid got=%b exp=0", l2_i_valid); end
        step;                                                 // t+4
        total++; if ({l2_i_valid, l2_d_valid} !== 2'b10) begin bad++;
            $display("FAIL fetch_valid got=%b exp=10", {l2_i_valid, l2_d_valid}); end
        total++; if (l2_i_rdata !== 32'h00A00093) begin bad++;
            $display("FAIL fetch_rdata got=%h exp=00a00093", l2_i_rdata); end
        i_req = 1'b0;
        step;                                                 // t+5
        total++; if ({l2_busy, l2_i_valid} !== 2'b00) begin bad++;
            $display("FAIL fetch_busy_drop got=%b exp=00", {l2_busy, l2_i_valid}); end
    endtask

    task automatic test_load_ext;
        logic [2:0]  f3   [2] = '{3'b000, 3'b100};
        logic [31:0] expv [2] = '{32'hFFFFFF80, 32'h00000080};
        do_reset;
        mem_rdata = 32'h80FF1234;
        for (int k = 0; k < 2; k++) begin
            d_addr = 32'h203; d_we = 1'b0; d_funct3 = f3[k]; d_req = 1'b1;   // cycle t
            step;                                                            // t+1
            total++; if ({l1_mem_en, l1_mem_addr} !== {1'b1, 32'h200}) begin bad++;
                $display("FAIL load%0d_access got=%b/%h exp=1/00000200", k, l1_mem_en,
                         l1_mem_addr); end
            step;                                                            // t+2
            total++; if (l1_d_valid !== 1'b0) begin bad++;
                $display("FAIL load%0d_early_valid got=%b exp=0", k, l1_d_valid); end
            step;                                                            // t+3
            total++; if ({l1_d_valid, l1_d_err, l1_i_valid} !== 3'b100) begin bad++;
                $display("FAIL load%0d_valid got=%b exp=100", k,
                         {l1_d_valid, l1_d_err, l1_i_valid}); end
            total++; if (l1_d_rdata !== expv[k]) begin bad++;
                $display("FAIL load%0d_rdata got=%h exp=%h", k, l1_d_rdata, expv[k]); end
            d_req = 1'b0;
            step;                                                            // idle
        end
    endtask

    task automatic test_store_half;
        do_reset;
        d_addr = 32'h302; d_wdata = 32'hDEADBEEF; d_funct3 = 3'b001; d_we = 1'b1;
        d_req = 1'b1;                                         // cycle t
        step;                                                 // t+1
        total++; if ({l1_mem_en, l1_mem_we, l1_mem_wstrb} !== 6'b111100) begin bad++;
            $display("FAIL sh_strobes got=%b exp=111100",
                     {l1_mem_en, l1_mem_we, l1_mem_wstrb}); end
        total++; if (l1_mem_wdata !== 32'hBEEFBEEF) begin bad++;
            $display("FAIL sh_wdata got=%h exp=beefbeef", l1_mem_wdata); end
        total++; if (l1_mem_addr !== 32'h300) begin bad++;
            $display("FAIL sh_addr got=%h exp=00000300", l1_mem_addr); end
        step;                                                 // t+2
        total++; if ({l1_d_valid, l1_d_err, l1_mem_en} !== 3'b100) begin bad++;
            $display("FAIL sh_valid got=%b exp=100", {l1_d_valid, l1_d_err, l1_mem_en}); end
        total++; if (l1_d_rdata !== 32'h0) begin bad++;
            $display("FAIL sh_rdata got=%h exp=0", l1_d_rdata); end
        d_req = 1'b0; d_we = 1'b0;
        step;
        total++; if (l1_busy !== 1'b0) begin bad++;
            $display("FAIL sh_busy got=%b exp=0", l1_busy); end
    endtask

    task automatic test_contention;
        int n = 0;
        int m = 0;
        logic exp_data;
        logic [31:0] exp_addr;
        reset = 1'b1;
        mem_rdata = 32'h0;
        d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h400; i_addr = 32'h500;
        i_req = 1'b1; d_req = 1'b1;
        step;
        step;
        reset = 1'b0;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            if (l2_mem_en) begin
                exp_addr = (m % 2 == 0) ? 32'h400 : 32'h500;
                total++; if (l2_mem_addr !== exp_addr) begin bad++;
                    $display("FAIL cont_grant%0d got=%h exp=%h", m, l2_mem_addr, exp_addr); end
                m++;
            end
            if (l2_i_valid || l2_d_valid) begin
                exp_data = (n % 2 == 0);
                total++; if ({l2_d_valid, l2_i_valid} !== {exp_data, !exp_data}) begin bad++;
                    $display("FAIL cont_valid%0d got=%b exp=%b", n, {l2_d_valid, l2_i_valid},
                             {exp_data, !exp_data}); end
                n++;
            end
            step;
        end
        total++; if (n !== 4) begin bad++;
            $display("FAIL cont_count got=%0d exp=4", n); end
        i_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_misaligned;
        logic [2:0]  f3   [2] = '{3'b010, 3'b111};
        do_reset;
        for (int k = 0; k < 2; k++) begin
            d_addr = 32'h0006; d_we = 1'b0; d_funct3 = f3[k]; d_req = 1'b1;  // cycle t
            step;                                                            // t+1
            total++; if ({l1_mem_en, l1_d_valid, l1_d_err} !== 3'b011) begin bad++;
                $display("FAIL err%0d_resp got=%b exp=011", k,
                         {l1_mem_en, l1_d_valid, l1_d_err}); end
            total++; if (l1_d_rdata !== 32'h0) begin bad++;
                $display("FAIL err%0d_rdata got=%h exp=0", k, l1_d_rdata); end
            d_req = 1'b0;
            step;
            total++; if ({l1_busy, l1_d_valid, l1_d_err, l1_mem_en} !== 4'b0000) begin bad++;
                $display("FAIL err%0d_idle got=%b exp=0000", k,
                         {l1_busy, l1_d_valid, l1_d_err, l1_mem_en}); end
        end
    endtask

    task automatic test_reset_wait;
        do_reset;
        mem_rdata = 32'h12345678;
        d_addr = 32'h10; d_we = 1'b0; d_funct3 = 3'b010; d_req = 1'b1;     // cycle t
        step;                                                             // t+1 ACCESS
        step;                                                             // t+2 WAIT
        total++; if ({l1_busy, l1_mem_en, l1_d_valid} !== 3'b100) begin bad++;
            $display("FAIL rstw_in_wait got=%b exp=100", {l1_busy, l1_mem_en, l1_d_valid}); end
        reset = 1'b1; d_req = 1'b0;
        #1;
        total++; if (l1_outs !== 138'h0) begin bad++;
            $display("FAIL rstw_async got=%h exp=0", l1_outs); end
        step;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++; if ({l1_d_valid, l1_busy} !== 2'b00) begin bad++;
                $display("FAIL rstw_no_valid%0d got=%b exp=00", k, {l1_d_valid, l1_busy}); end
            step;
        end
        d_req = 1'b1;                                                     // new t
        step;
        step;
        step;
        total++; if ({l1_d_valid, l1_d_err, l1_d_rdata} !== {2'b10, 32'h12345678}) begin bad++;
            $display("FAIL rstw_after got=%b/%b/%h exp=1/0/12345678", l1_d_valid, l1_d_err,
                     l1_d_rdata); end
        d_req = 1'b0;
        step;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset;
        test_fetch;
        test_load_ext;
        test_store_half;
        test_contention;
        test_misaligned;
        test_reset_wait;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
